// File: rtl/regfile_2r1w_clr.sv
// 32-entry register file with two combinational read ports, one write port,
// self-clearing after reset, hardwired-zero entry 0 and same-cycle write bypass.
module regfile_2r1w_clr #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr1,
  input  logic [AWIDTH-1:0] raddr2,
  output logic [DWIDTH-1:0] rdata1,
  output logic [DWIDTH-1:0] rdata2,
  output logic              ready,
  output logic              wr_drop
);

  localparam int NREGS = 2 ** AWIDTH;
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              wr_drop_q, wr_drop_d;

  logic [DWIDTH-1:0] mem_q [NREGS];
  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              ext_wr;

  assign ext_wr = we && (waddr != '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    wr_drop_d = 1'b0;
    if (state_q == S_INIT) begin
      cnt_d     = cnt_q + AWIDTH'(1);
      wr_drop_d = we;
      if (cnt_q == AWIDTH'(NREGS - 1)) begin
        state_d = S_RUN;
        ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_INIT;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // The clear sequencer owns the write port while INIT; reset itself never writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    if (rst_n) begin
      if (state_q == S_INIT) begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
      end else begin
        mem_we = ext_wr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (state_q == S_RUN) begin
      if (raddr1 != '0) begin
        rdata1 = (ext_wr && (waddr == raddr1)) ? wdata : mem_q[raddr1];
      end
      if (raddr2 != '0) begin
        rdata2 = (ext_wr && (waddr == raddr2)) ? wdata : mem_q[raddr2];
      end
    end
  end

  assign ready   = ready_q;
  assign wr_drop = wr_drop_q;

endmodule
